taylor_frame_seq: RTL and testbench

- Frame sequencer wrapped around the floating-point processor core and its integer/float converters.
- Collects NIN integer input samples from an upstream valid/ready stream into per-port holding registers.
- Releases the processor from reset, serves its one-hot input requests from those registers, and captures its one-hot output strobes into per-port result registers.
- Once every output port has been written, holds the processor in reset and streams the results downstream in port order.

---
 rtl/taylor_frame_seq.sv | 252 +++++++++++++++++++++++++
 tb/tb_taylor_frame_seq.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/taylor_frame_seq.sv
`default_nettype none
// ============================================================================
//  Module   : taylor_frame_seq
//  Purpose  : Frame sequencer around the floating-point processor core.
//             Collects NIN signed integer samples from an upstream
//             valid/ready stream, releases the processor from reset, serves
//             its one-hot input requests, captures its one-hot output strobes
//             and, once every output port has been written, holds the
//             processor in reset while the results are streamed downstream
//             in port order.
//  Ports    : clk, rst                 - clock, synchronous active-high reset
//             s_valid/s_data/s_ready   - upstream sample stream (port order)
//             m_valid/m_data/m_port/
//             m_last/m_ready           - downstream result stream
//             proc_rst                 - processor reset (active high)
//             io_in/req_in             - processor input path
//             io_out/out_en            - processor output path
//             busy, err_flags,
//             frame_cnt                - status
//  Options  : SEQ_TIMEOUT_EN - RUN-state watchdog of TMO cycles; on expiry
//             err_flags[2] is set and DRAIN is forced (unwritten ports
//             output 0). Undefined: no watchdog, err_flags[2] stays 0.
//  Revision : 1.0 - initial release
// ============================================================================
module taylor_frame_seq #(
    parameter int NIN  = 4,
    parameter int NOUT = 4,
    parameter int IW   = 19,
    parameter int OW   = 28,
    parameter int TMO  = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    input  logic [IW-1:0]           s_data,
    output logic                    s_ready,
    output logic                    m_valid,
    output logic [OW-1:0]           m_data,
    output logic [$clog2(NOUT)-1:0] m_port,
    output logic                    m_last,
    input  logic                    m_ready,
    output logic                    proc_rst,
    output logic [IW-1:0]           io_in,
    input  logic [NIN-1:0]          req_in,
    input  logic [OW-1:0]           io_out,
    input  logic [NOUT-1:0]         out_en,
    output logic                    busy,
    output logic [2:0]              err_flags,
    output logic [15:0]             frame_cnt
);

    localparam int c_IDX_W  = (NIN > 1) ? $clog2(NIN) : 1;
    localparam int c_PORT_W = $clog2(NOUT);

    localparam logic [c_IDX_W-1:0]  c_IN_LAST   = c_IDX_W'(NIN - 1);
    localparam logic [c_PORT_W-1:0] c_PORT_LAST = c_PORT_W'(NOUT - 1);

    localparam logic [1:0] c_ST_LOAD  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [c_IDX_W-1:0]  r_in_idx;
    logic [IW-1:0]       r_hold [NIN];
    logic [OW-1:0]       r_res  [NOUT];
    logic [NOUT-1:0]     r_cap;
    logic [c_PORT_W-1:0] r_port;
    logic                r_proc_rst;
    logic                r_s_ready;
    logic [2:0]          r_err;
    logic [15:0]         r_frame_cnt;

    logic [1:0]          w_state_nxt;
    logic                w_accept;
    logic                w_take;
    logic [NOUT-1:0]     w_cap_nxt;
    logic [NOUT-1:0]     w_cap_run;
    logic                w_cap_full;
    logic                w_run;
    logic                w_tmo_hit;
    logic                w_req_multi;
    logic                w_en_multi;
    logic [IW-1:0]       w_io_sel;

    assign w_run      = (r_state == c_ST_RUN);
    assign w_cap_run  = r_cap | out_en;
    assign w_cap_full = &w_cap_run;

    // x & (x-1) is non-zero exactly when more than one bit is set.
    assign w_req_multi = |(req_in & (req_in - {{(NIN-1){1'b0}}, 1'b1}));
    assign w_en_multi  = |(out_en & (out_en - {{(NOUT-1){1'b0}}, 1'b1}));

    // ------------------------------------------------------------------
    // Input path: lowest requested port wins; descending scan so the
    // last assignment made is the lowest set bit.
    // ------------------------------------------------------------------
    always_comb begin
        w_io_sel = '0;
        for (int k = NIN - 1; k >= 0; k--) begin
            if (req_in[k]) begin
                w_io_sel = r_hold[k];
            end
        end
    end

    assign io_in = w_run ? w_io_sel : '0;

    // ------------------------------------------------------------------
    // RUN-state watchdog
    // ------------------------------------------------------------------
`ifdef SEQ_TIMEOUT_EN
    localparam int c_TMO_W = ($clog2(TMO + 1) > 13) ? $clog2(TMO + 1) : 13;

    logic [c_TMO_W-1:0] r_tmo_cnt;

    // Held at zero outside RUN, so it restarts from zero on every RUN entry.
    // A hit on the TMO-th RUN cycle makes DRAIN the state TMO cycles after
    // RUN was entered.
    always_ff @(posedge clk) begin
        if (rst || !w_run) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
        end
    end

    assign w_tmo_hit = w_run && (r_tmo_cnt == c_TMO_W'(TMO - 1));
`else
    // Watchdog compiled out; TMO is referenced only so the parameter list
    // stays identical between builds.
    assign w_tmo_hit = 1'b0 & (TMO > 0);
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_take      = 1'b0;
        w_cap_nxt   = r_cap;
        case (r_state)
            c_ST_LOAD: begin
                w_accept = s_valid && r_s_ready;
                if (w_accept && (r_in_idx == c_IN_LAST)) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                // Completion is judged on the captures made this cycle.
                w_cap_nxt = w_cap_run;
                if (w_cap_full || w_tmo_hit) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                w_take = m_ready;
                if (m_ready && (r_port == c_PORT_LAST)) begin
                    w_cap_nxt   = '0;
                    w_state_nxt = c_ST_LOAD;
                end
            end
            default: begin
                w_state_nxt = c_ST_LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_LOAD;
            r_in_idx    <= '0;
            r_cap       <= '0;
            r_port      <= '0;
            r_proc_rst  <= 1'b1;
            r_s_ready   <= 1'b0;
            r_err       <= '0;
            r_frame_cnt <= '0;
            for (int i = 0; i < NIN; i++) begin
                r_hold[i] <= '0;
            end
            for (int j = 0; j < NOUT; j++) begin
                r_res[j] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_cap   <= w_cap_nxt;

            // Registered from the next state so the processor reset and the
            // upstream ready change on the same edge as the state itself.
            r_proc_rst <= (w_state_nxt != c_ST_RUN);
            r_s_ready  <= (w_state_nxt == c_ST_LOAD);

            if (w_accept) begin
                r_hold[r_in_idx] <= s_data;
                r_in_idx         <= (r_in_idx == c_IN_LAST) ? '0
                                                            : r_in_idx + c_IDX_W'(1);
            end

            if (w_run) begin
                for (int j = 0; j < NOUT; j++) begin
                    if (out_en[j]) begin
                        r_res[j] <= io_out;
                    end
                end
            end

            if (w_take) begin
                if (r_port == c_PORT_LAST) begin
                    r_port      <= '0;
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end else begin
                    r_port <= r_port + c_PORT_W'(1);
                end
            end

            if (!w_run && (|req_in)) begin
                r_err[0] <= 1'b1;
            end
            if (w_run && (w_req_multi || w_en_multi)) begin
                r_err[1] <= 1'b1;
            end
            // A frame that completes on the very cycle the watchdog expires
            // is not reported as a timeout.
            if (w_tmo_hit && !w_cap_full) begin
                r_err[2] <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign m_valid   = (r_state == c_ST_DRAIN);
    // Ports never written (watchdog drain) read as zero.
    assign m_data    = (m_valid && r_cap[r_port]) ? r_res[r_port] : '0;
    assign m_port    = r_port;
    assign m_last    = m_valid && (r_port == c_PORT_LAST);
    assign proc_rst  = r_proc_rst;
    assign s_ready   = r_s_ready;
    assign busy      = !((r_state == c_ST_LOAD) && (r_in_idx == '0));
    assign err_flags = r_err;
    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_taylor_frame_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_taylor_frame_seq
//  Purpose  : Self-checking bench for taylor_frame_seq. Directed frames use
//             constant vector tables; random frames are checked against a
//             behavioural model (held samples, last-written result per port,
//             sticky error bits, frame count).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_taylor_frame_seq;

    localparam int NIN  = 4;
    localparam int NOUT = 4;
    localparam int IW   = 19;
    localparam int OW   = 28;
    localparam int TMO  = 50;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic [IW-1:0]     s_data = '0;
    logic              s_ready;
    logic              m_valid;
    logic [OW-1:0]     m_data;
    logic [1:0]        m_port;
    logic              m_last;
    logic              m_ready = 1'b0;
    logic              proc_rst;
    logic [IW-1:0]     io_in;
    logic [NIN-1:0]    req_in = '0;
    logic [OW-1:0]     io_out = '0;
    logic [NOUT-1:0]   out_en = '0;
    logic              busy;
    logic [2:0]        err_flags;
    logic [15:0]       frame_cnt;

    taylor_frame_seq #(
        .NIN (NIN),
        .NOUT(NOUT),
        .IW  (IW),
        .OW  (OW),
        .TMO (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_port   (m_port),
        .m_last   (m_last),
        .m_ready  (m_ready),
        .proc_rst (proc_rst),
        .io_in    (io_in),
        .req_in   (req_in),
        .io_out   (io_out),
        .out_en   (out_en),
        .busy     (busy),
        .err_flags(err_flags),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard / reference model
    // ------------------------------------------------------------------
    int            n_checks = 0;
    int            n_errors = 0;
    logic [IW-1:0] hold_m [NIN];
    logic [OW-1:0] res_m  [NOUT];
    logic [2:0]    err_m = '0;
    int            fc_m  = 0;

    typedef struct {
        logic [NIN-1:0] req;
        logic [IW-1:0]  exp_io;
        logic [2:0]     exp_err;
    } vec_t;

    vec_t tv [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Processor input path: the lowest requested port's held sample.
    function automatic logic [IW-1:0] exp_io(input logic [NIN-1:0] r);
        for (int k = 0; k < NIN; k++) begin
            if (r[k]) return hold_m[k];
        end
        return '0;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [IW-1:0] smp [NIN]);
        int n;
        for (int j = 0; j < NOUT; j++) res_m[j] = '0;
        for (int i = 0; i < NIN; i++) begin
            s_valid   = 1'b1;
            s_data    = smp[i];
            hold_m[i] = smp[i];
            #1;
            n = 0;
            while (!s_ready && n < 20) begin
                cyc();
                #1;
                n++;
            end
            if (!s_ready) chk("s_ready_wait", {63'd0, s_ready}, 64'd1);
            if (i == NIN - 1) begin
                chk("proc_rst_before_last", {63'd0, proc_rst}, 64'd1);
                chk("busy_loading", {63'd0, busy}, 64'd1);
            end
            cyc();
        end
        s_valid = 1'b0;
        #1;
        chk("proc_rst_run", {63'd0, proc_rst}, 64'd0);
        chk("s_ready_run", {63'd0, s_ready}, 64'd0);
    endtask

    // One processor cycle: request and/or strobe, with the model updated.
    task automatic op(input logic [NIN-1:0] req, input logic [NOUT-1:0] en,
                      input logic [OW-1:0] val, input bit in_run);
        req_in = req;
        out_en = en;
        io_out = val;
        #1;
        chk("io_in", 64'(io_in), in_run ? 64'(exp_io(req)) : 64'd0);
        if (in_run) begin
            for (int j = 0; j < NOUT; j++) if (en[j]) res_m[j] = val;
            if ($countones(req) > 1 || $countones(en) > 1) err_m[1] = 1'b1;
        end else if (req != '0) begin
            err_m[0] = 1'b1;
        end
        cyc();
        req_in = '0;
        out_en = '0;
        io_out = '0;
    endtask

    task automatic drain(input int stall_port, input int stall_len, input bit rnd);
        int st;
        int n;
        for (int p = 0; p < NOUT; p++) begin
            st = 0;
            n  = 0;
            forever begin
                if (rnd) m_ready = (n >= 20) || ($urandom_range(0, 2) != 0);
                else     m_ready = !(p == stall_port && st < stall_len);
                #1;
                chk("m_valid", {63'd0, m_valid}, 64'd1);
                chk("m_port", 64'(m_port), 64'(p));
                chk("m_data", 64'(m_data), 64'(res_m[p]));
                chk("m_last", {63'd0, m_last}, (p == NOUT - 1) ? 64'd1 : 64'd0);
                chk("s_ready_drain", {63'd0, s_ready}, 64'd0);
                chk("proc_rst_drain", {63'd0, proc_rst}, 64'd1);
                if (m_ready) begin
                    cyc();
                    break;
                end
                cyc();
                st++;
                n++;
            end
        end
        m_ready = 1'b0;
        fc_m++;
        #1;
        chk("frame_cnt", 64'(frame_cnt), 64'(fc_m));
        chk("m_valid_after", {63'd0, m_valid}, 64'd0);
        chk("s_ready_after", {63'd0, s_ready}, 64'd1);
        chk("busy_after", {63'd0, busy}, 64'd0);
        chk("err_flags", 64'(err_flags), 64'(err_m));
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IW-1:0]   smp [NIN];
        logic [NIN-1:0]  r;
        logic [NOUT-1:0] e;
        logic [NOUT-1:0] cov;
        int              nops;
        bit              found;

        tv[0] = '{4'b0001, 19'd10,    3'b000};
        tv[1] = '{4'b0010, -19'sd3,   3'b000};
        tv[2] = '{4'b0100, 19'd7,     3'b000};
        tv[3] = '{4'b1000, 19'd100,   3'b000};
        tv[4] = '{4'b0000, 19'd0,     3'b000};
        tv[5] = '{4'b0001, 19'd10,    3'b000};
        tv[6] = '{4'b0100, 19'd7,     3'b000};

        // ---------------- reset values ----------------
        rst = 1'b1;
        repeat (3) cyc();
        #1;
        chk("rst_proc_rst", {63'd0, proc_rst}, 64'd1);
        chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
        chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_m_port", 64'(m_port), 64'd0);
        chk("rst_m_last", {63'd0, m_last}, 64'd0);
        chk("rst_err", 64'(err_flags), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_io_in", 64'(io_in), 64'd0);
        rst = 1'b0;
        cyc();

        // ---------------- normal frame ----------------
        smp = '{19'd10, -19'sd3, 19'd7, 19'd100};
        send_frame(smp);
        for (int i = 0; i < 7; i++) begin
            req_in = tv[i].req;
            #1;
            chk("tv_io_in", 64'(io_in), 64'(tv[i].exp_io));
            chk("tv_err", 64'(err_flags), 64'(tv[i].exp_err));
            chk("tv_busy", {63'd0, busy}, 64'd1);
            cyc();
            req_in = '0;
        end
        op('0, 4'b0010, 28'd2500, 1);
        op('0, 4'b0001, 28'd11, 1);
        op('0, 4'b0100, -28'sd42, 1);
        op('0, 4'b1000, 28'd123456, 1);
        #1;
        chk("last_cap_proc_rst", {63'd0, proc_rst}, 64'd1);
        chk("last_cap_m_valid", {63'd0, m_valid}, 64'd1);
        drain(0, 0, 0);

        // ---------------- backpressure ----------------
        smp = '{19'd1, 19'd2, 19'd3, 19'd4};
        send_frame(smp);
        op('0, 4'b0001, 28'd100, 1);
        op('0, 4'b0010, 28'd200, 1);
        op('0, 4'b0100, 28'd300, 1);
        op('0, 4'b1000, 28'd400, 1);
        drain(2, 5, 0);

        // ---------------- overwrite and multi-hot request ----------------
        smp = '{19'd21, 19'd22, 19'd23, 19'd24};
        send_frame(smp);
        op('0, 4'b0001, 28'd5, 1);
        op('0, 4'b0001, 28'd9, 1);
        op(4'b0011, '0, '0, 1);
        chk("err_multi", 64'(err_flags), 64'b010);
        op('0, 4'b0010, 28'd7, 1);
        op('0, 4'b0100, 28'd8, 1);
        op('0, 4'b1000, 28'd6, 1);
        drain(0, 0, 0);

        // ---------------- protocol errors in LOAD ----------------
        op(4'b0001, '0, '0, 0);
        chk("err_underrun", 64'(err_flags), 64'b011);
        op('0, 4'b1111, 28'd77, 0);
        smp = '{19'd31, 19'd32, 19'd33, 19'd34};
        send_frame(smp);
        op('0, '0, '0, 1);
        chk("no_early_drain", {63'd0, m_valid}, 64'd0);
        op('0, 4'b0001, 28'd41, 1);
        op('0, 4'b0010, 28'd42, 1);
        op('0, 4'b0100, 28'd43, 1);
        op('0, 4'b1000, 28'd44, 1);
        drain(0, 0, 1);

        // ---------------- mid-frame reset ----------------
        smp = '{19'd5, 19'd6, 19'd7, 19'd8};
        send_frame(smp);
        op('0, 4'b0001, 28'd1, 1);
        op('0, 4'b0010, 28'd2, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("mrst_proc_rst", {63'd0, proc_rst}, 64'd1);
        chk("mrst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("mrst_err", 64'(err_flags), 64'd0);
        chk("mrst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("mrst_busy", {63'd0, busy}, 64'd0);
        err_m = '0;
        fc_m  = 0;
        smp = '{19'd50, 19'd51, 19'd52, 19'd53};
        send_frame(smp);
        op('0, 4'b1000, 28'd13, 1);
        op('0, 4'b0100, 28'd12, 1);
        op('0, 4'b0010, 28'd11, 1);
        op('0, 4'b0001, 28'd10, 1);
        drain(0, 0, 0);

        // ---------------- randomized frames ----------------
        for (int f = 0; f < 20; f++) begin
            r = ($urandom_range(0, 3) == 0) ? NIN'($urandom) : '0;
            op(r, NOUT'($urandom), OW'($urandom), 0);
            for (int i = 0; i < NIN; i++) smp[i] = IW'($urandom);
            send_frame(smp);
            cov  = '0;
            nops = 0;
            while (cov != '1) begin
                if (nops < 30) begin
                    r = ($urandom_range(0, 1) == 0) ? '0 : NIN'($urandom);
                    case ($urandom_range(0, 2))
                        0:       e = '0;
                        1:       e = NOUT'(1) << $urandom_range(0, NOUT - 1);
                        default: e = NOUT'($urandom);
                    endcase
                end else begin
                    r     = '0;
                    e     = '0;
                    found = 1'b0;
                    for (int j = 0; j < NOUT; j++) begin
                        if (!cov[j] && !found) begin
                            e[j]  = 1'b1;
                            found = 1'b1;
                        end
                    end
                end
                op(r, e, OW'($urandom), 1);
                cov |= e;
                nops++;
            end
            drain(0, 0, 1);
        end

`ifdef SEQ_TIMEOUT_EN
        // ---------------- watchdog ----------------
        smp = '{19'd60, 19'd61, 19'd62, 19'd63};
        send_frame(smp);
        op('0, 4'b0001, 28'd555, 1);
        for (int i = 1; i < TMO; i++) begin
            #1;
            chk("tmo_wait", {63'd0, m_valid}, 64'd0);
            cyc();
        end
        err_m[2] = 1'b1;
        #1;
        chk("tmo_drain", {63'd0, m_valid}, 64'd1);
        chk("tmo_flag", {63'd0, err_flags[2]}, 64'd1);
        drain(0, 0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
